// File: rtl/render_handler.sv
// Frame renderer: on drawEn, sweeps the 160x120 screen in raster order and streams one
// composed pixel per cycle (HUD bars, ships, bullets) to the vga_adapter write port.
module render_handler #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned SHIP_W   = 8,
  parameter int unsigned SHIP_H   = 4,
  parameter int unsigned HUD_ROWS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         drawEn,
  input  logic [7:0]                   user_x,
  input  logic [6:0]                   user_y,
  input  logic [7:0]                   enemy_x,
  input  logic [6:0]                   enemy_y,
  input  logic [SCREEN_W*SCREEN_H-1:0] grid,
  input  logic [3:0]                   ship_health,
  input  logic [3:0]                   gun_cooldown,
  output logic [7:0]                   vga_x,
  output logic [6:0]                   vga_y,
  output logic [2:0]                   colour,
  output logic                         plot,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {StIdle, StScan, StFinish} state_e;

  state_e     state_q;
  logic [7:0] sx_q;
  logic [6:0] sy_q;
  logic [7:0] ux_q, ex_q;
  logic [6:0] uy_q, ey_q;
  logic [3:0] health_q, cool_q;

  logic [2:0]  colour_d;
  logic        in_user, in_enemy;
  logic [14:0] pix_idx;

  // Box bounds widened by one bit so boxes at the right/bottom edge clip instead of wrapping.
  always_comb begin
    in_user  = ({1'b0, sx_q} >= {1'b0, ux_q}) && ({1'b0, sx_q} < {1'b0, ux_q} + 9'(SHIP_W)) &&
               ({1'b0, sy_q} >= {1'b0, uy_q}) && ({1'b0, sy_q} < {1'b0, uy_q} + 8'(SHIP_H));
    in_enemy = ({1'b0, sx_q} >= {1'b0, ex_q}) && ({1'b0, sx_q} < {1'b0, ex_q} + 9'(SHIP_W)) &&
               ({1'b0, sy_q} >= {1'b0, ey_q}) && ({1'b0, sy_q} < {1'b0, ey_q} + 8'(SHIP_H));
    pix_idx  = 15'(sy_q) * 15'(SCREEN_W) + 15'(sx_q);
  end

  always_comb begin
    colour_d = 3'b000;
    if (sy_q < 7'(HUD_ROWS)) begin
      if (sy_q < 7'd2) begin
        if (sx_q < {2'b00, health_q, 2'b00}) colour_d = 3'b010;
      end else if (sx_q < {2'b00, cool_q, 2'b00}) begin
        colour_d = (cool_q == 4'b1111) ? 3'b100 : 3'b110;
      end
    end else if (in_user) begin
      colour_d = 3'b001;
    end else if (in_enemy) begin
      colour_d = 3'b100;
    end else if (grid[pix_idx]) begin
      colour_d = 3'b111;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sx_q     <= '0;
      sy_q     <= '0;
      ux_q     <= '0;
      uy_q     <= '0;
      ex_q     <= '0;
      ey_q     <= '0;
      health_q <= '0;
      cool_q   <= '0;
      vga_x    <= '0;
      vga_y    <= '0;
      colour   <= 3'b000;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (drawEn) begin
            ux_q     <= user_x;
            uy_q     <= user_y;
            ex_q     <= enemy_x;
            ey_q     <= enemy_y;
            health_q <= ship_health;
            cool_q   <= gun_cooldown;
            sx_q     <= '0;
            sy_q     <= '0;
            busy     <= 1'b1;
            state_q  <= StScan;
          end
        end
        StScan: begin
          vga_x  <= sx_q;
          vga_y  <= sy_q;
          colour <= colour_d;
          plot   <= 1'b1;
          if (sx_q == 8'(SCREEN_W - 1)) begin
            sx_q <= '0;
            if (sy_q == 7'(SCREEN_H - 1)) begin
              state_q <= StFinish;
            end else begin
              sy_q <= sy_q + 7'd1;
            end
          end else begin
            sx_q <= sx_q + 8'd1;
          end
        end
        StFinish: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_render_handler.sv
// Directed bench for render_handler: captures whole frames into a framebuffer and checks
// timing, pixel colours and pixel counts against hand-computed values.
module tb_render_handler;

  logic           clk = 1'b0;
  logic           reset;
  logic           drawEn;
  logic [7:0]     user_x, enemy_x;
  logic [6:0]     user_y, enemy_y;
  logic [19199:0] grid;
  logic [3:0]     ship_health, gun_cooldown;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     colour;
  logic           plot, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  int fb [19200];
  int nplots, first_n, last_n, first_x, first_y, last_x, last_y;
  int done_cnt, done_n, busy_at_done, busy_mid, plot_after_rst, busy_after_rst;

  always #5 clk = ~clk;

  render_handler dut (
    .clk         (clk),
    .reset       (reset),
    .drawEn      (drawEn),
    .user_x      (user_x),
    .user_y      (user_y),
    .enemy_x     (enemy_x),
    .enemy_y     (enemy_y),
    .grid        (grid),
    .ship_health (ship_health),
    .gun_cooldown(gun_cooldown),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int px(input int x, input int y);
    return fb[y * 160 + x];
  endfunction

  function automatic int count_col(input int c);
    int cnt = 0;
    for (int i = 0; i < 19200; i++) if (fb[i] == c) cnt++;
    return cnt;
  endfunction

  // Pulses drawEn and records one frame. disturb_n: cycle to re-pulse drawEn and move the
  // user ship; reset_n: cycle to assert reset (0 disables either).
  task automatic run_frame(input int disturb_n, input int reset_n);
    int  n;
    int  idx;
    bit  stop;
    nplots = 0; first_n = -1; last_n = -1; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    done_cnt = 0; done_n = -1; busy_at_done = -1; busy_mid = -1;
    plot_after_rst = -1; busy_after_rst = -1;
    for (int i = 0; i < 19200; i++) fb[i] = -1;
    @(negedge clk);
    drawEn = 1'b1;
    n = 0;
    stop = 1'b0;
    while (!stop) begin
      @(negedge clk);
      n++;
      if (plot) begin
        idx = int'(vga_y) * 160 + int'(vga_x);
        if (idx < 19200) fb[idx] = int'(colour);
        if (nplots == 0) begin
          first_n = n; first_x = int'(vga_x); first_y = int'(vga_y);
        end
        last_n = n; last_x = int'(vga_x); last_y = int'(vga_y);
        nplots++;
      end
      if (done) begin
        done_cnt++;
        if (done_n < 0) begin
          done_n = n;
          busy_at_done = int'(busy);
        end
      end
      if (n == 100) busy_mid = int'(busy);
      if (reset_n > 0 && n == reset_n + 1) begin
        plot_after_rst = int'(plot);
        busy_after_rst = int'(busy);
      end
      drawEn = (disturb_n > 0 && n == disturb_n);
      if (disturb_n > 0 && n == disturb_n) user_x = 8'd90;
      reset = (reset_n > 0 && n == reset_n);
      if (done_n > 0 && n >= done_n + 3) stop = 1'b1;
      if (reset_n > 0 && n >= reset_n + 20) stop = 1'b1;
      if (n >= 19400) stop = 1'b1;
    end
    drawEn = 1'b0;
    reset  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; drawEn = 1'b0;
    user_x = '0; user_y = '0; enemy_x = '0; enemy_y = '0;
    grid = '0; ship_health = '0; gun_cooldown = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_plot",   int'(plot),   0);
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_x",      int'(vga_x),  0);
    check("rst_y",      int'(vga_y),  0);
    check("rst_colour", int'(colour), 0);

    // Frame A: everything zero, timing of the sweep.
    run_frame(0, 0);
    check("a_nplots",   nplots, 19200);
    check("a_first_n",  first_n, 2);
    check("a_last_n",   last_n, 19201);
    check("a_first_xy", first_x * 1000 + first_y, 0);
    check("a_last_xy",  last_x * 1000 + last_y, 159119);
    check("a_busy_mid", busy_mid, 1);
    check("a_done_cnt", done_cnt, 1);
    check("a_done_n",   done_n, 19202);
    check("a_busy_dn",  busy_at_done, 0);
    check("a_black",    count_col(0), 19200);

    // Frame B: ships and bullets, one bullet under the user ship.
    user_x = 8'd40; user_y = 7'd50; enemy_x = 8'd150; enemy_y = 7'd20;
    grid[50 * 160 + 40] = 1'b1;
    grid[80 * 160 + 100] = 1'b1;
    run_frame(0, 0);
    check("b_nplots",   nplots, 19200);
    check("b_blue",     count_col(1), 32);
    check("b_red",      count_col(4), 32);
    check("b_white",    count_col(7), 1);
    check("b_40_50",    px(40, 50), 1);
    check("b_47_53",    px(47, 53), 1);
    check("b_48_53",    px(48, 53), 0);
    check("b_40_54",    px(40, 54), 0);
    check("b_100_80",   px(100, 80), 7);
    check("b_150_20",   px(150, 20), 4);
    check("b_157_23",   px(157, 23), 4);
    check("b_158_23",   px(158, 23), 0);

    // Frame C: HUD bars, clipped enemy, user under HUD, mid-frame drawEn and user_x change.
    grid = '0;
    user_x = 8'd20; user_y = 7'd2; enemy_x = 8'd156; enemy_y = 7'd118;
    ship_health = 4'd3; gun_cooldown = 4'b1111;
    run_frame(1000, 0);
    check("c_nplots",   nplots, 19200);
    check("c_done_cnt", done_cnt, 1);
    check("c_green",    count_col(2), 24);
    check("c_red",      count_col(4), 128);
    check("c_blue",     count_col(1), 16);
    check("c_11_0",     px(11, 0), 2);
    check("c_12_0",     px(12, 0), 0);
    check("c_20_2",     px(20, 2), 4);
    check("c_59_3",     px(59, 3), 4);
    check("c_60_3",     px(60, 3), 0);
    check("c_20_4",     px(20, 4), 1);
    check("c_90_4",     px(90, 4), 0);
    check("c_156_118",  px(156, 118), 4);
    check("c_159_119",  px(159, 119), 4);
    check("c_155_118",  px(155, 118), 0);
    check("c_0_118",    px(0, 118), 0);
    check("c_3_119",    px(3, 119), 0);

    // Frame D: yellow cooldown bar, reset asserted right after pixel 5000 is plotted.
    user_x = 8'd0; user_y = 7'd100; enemy_x = 8'd0; enemy_y = 7'd0;
    ship_health = 4'd0; gun_cooldown = 4'd5;
    run_frame(0, 5002);
    check("d_nplots",   nplots, 5001);
    check("d_plot_rst", plot_after_rst, 0);
    check("d_busy_rst", busy_after_rst, 0);
    check("d_done_cnt", done_cnt, 0);
    check("d_yellow",   count_col(6), 40);
    check("d_19_2",     px(19, 2), 6);
    check("d_20_2",     px(20, 2), 0);

    // Frame E: restart after reset; bullet at (40,50) now uncovered.
    gun_cooldown = 4'd0;
    grid[50 * 160 + 40] = 1'b1;
    run_frame(0, 0);
    check("e_nplots",   nplots, 19200);
    check("e_first_n",  first_n, 2);
    check("e_first_xy", first_x * 1000 + first_y, 0);
    check("e_done_cnt", done_cnt, 1);
    check("e_40_50",    px(40, 50), 7);
    check("e_white",    count_col(7), 1);
    check("e_blue",     count_col(1), 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/render_handler.md
Name: render_handler

Overview:
- Consumer side of the game-state interface driven by logic_handler.
- Once per frame, on a drawEn request from the top-level FSM, it sweeps every pixel of the 160x120 screen in raster order.
- For each pixel it composes the colour from ship/enemy positions, the bullet grid and HUD values, and drives the vga_adapter write port (x, y, colour, plot).
- Reports completion with a done pulse so the FSM can advance to shipUpdateEn/gridUpdateEn.

Parameters:
- SCREEN_W, 160, pixel columns.
- SCREEN_H, 120, pixel rows.
- SHIP_W, 8, width in pixels of user and enemy ship boxes.
- SHIP_H, 4, height in pixels of user and enemy ship boxes.
- HUD_ROWS, 4, top rows reserved for the health and cooldown bars.

Ports:
- clk  input  1  system clock (50 MHz)
- reset  input  1  synchronous, active-high reset
- drawEn  input  1  FSM request to start one full frame sweep
- user_x  input  8  user ship left column
- user_y  input  7  user ship top row
- enemy_x  input  8  enemy ship left column
- enemy_y  input  7  enemy ship top row
- grid  input  19200  bullet bitmap, bit index y*160+x, 1 = bullet
- ship_health  input  4  user health, 0..15
- gun_cooldown  input  4  gun heat, 4'b1111 = overheated
- vga_x  output  8  pixel column to vga_adapter
- vga_y  output  7  pixel row to vga_adapter
- colour  output  3  RGB pixel colour
- plot  output  1  write strobe to vga_adapter
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse after the last pixel is plotted

Behaviour:
- Single clock, clk. reset is synchronous and active-high.
- Reset values: vga_x=0, vga_y=0, colour=3'b000, plot=0, busy=0, done=0, state=IDLE, scan counters=0.
- States: IDLE, SCAN, FINISH.
- IDLE: drawEn=1 latches user_x/y, enemy_x/y, ship_health and gun_cooldown into snapshot registers, clears scan counters (sx=0, sy=0), and moves to SCAN. busy rises on the next edge.
- SCAN: one pixel per cycle.
  - sx increments 0..159.
  - At sx=159, sx wraps to 0 and sy increments.
  - At (159,119) the state moves to FINISH.
- Output pipeline, one cycle registered:
  - The pixel at counter (sx,sy) in cycle t appears on vga_x/vga_y/colour with plot=1 in cycle t+1.
  - The first plot is at (0,0), two cycles after drawEn is sampled.
  - plot is high for exactly 19200 consecutive cycles per frame.
- FINISH:
  - plot=0.
  - done=1 for exactly one cycle, in the cycle after the last plot.
  - busy falls in the same cycle.
  - Returns to IDLE.
- drawEn is ignored in SCAN and FINISH (no restart, no queueing). drawEn held high in IDLE starts a new frame immediately after FINISH.
- Colour priority per pixel, highest first:
  1. HUD health bar: sy in 0..1 and sx < ship_health*4 -> 3'b010 green.
  2. HUD cooldown bar: sy in 2..3 and sx < gun_cooldown*4 -> 3'b110 yellow, or 3'b100 red when gun_cooldown=4'b1111.
  3. Any other HUD-row pixel -> 3'b000.
  4. User ship: user_x <= sx < user_x+SHIP_W and user_y <= sy < user_y+SHIP_H -> 3'b001 blue.
  5. Enemy ship: same box test at enemy_x/enemy_y -> 3'b100 red.
  6. Bullet: grid[sy*160+sx]=1 -> 3'b111 white.
  7. Otherwise 3'b000.
- Box-bound arithmetic is done in 9 bits (x) and 8 bits (y), so boxes near the right or bottom edge clip and never wrap to column or row 0.
- Positions and HUD values come from the snapshot, so a mid-frame change has no effect until the next frame.
- grid is sampled live, one bit per cycle.
- reset mid-frame: on the next edge plot=0, busy=0, done=0, state=IDLE, and no further pixels are emitted.

Test Plan:
- Reset, then drawEn pulse with all inputs 0 -> plot high 19200 consecutive cycles starting 2 cycles after drawEn; first (0,0), last (159,119); done single pulse in the cycle after the last plot; busy low after.
- user_x=10, user_y=100, enemy=(150,20), grid=0 -> blue exactly at x 10..17, y 100..103; red at x 150..157, y 20..23; all other non-HUD pixels black.
- enemy_x=156, enemy_y=118 -> red only at x 156..159, y 118..119; x 0..3 on rows 118..119 stay black.
- ship_health=3, gun_cooldown=4'b1111 -> rows 0..1 green at x 0..11 only; rows 2..3 red at x 0..59; ship placed at y=2 is not visible in rows 2..3.
- grid bit 50*160+40 set, user box covering (40,50) -> pixel (40,50) blue; same bit with ship moved away -> white.
- drawEn re-pulsed mid-frame and user_x changed mid-frame -> still exactly 19200 plots, ship drawn at the snapshot x; reset asserted at pixel 5000 -> plot=0 next cycle, no done pulse, a fresh drawEn restarts at (0,0).
